// File: rtl/pulse_encoder_if.sv
// pulse_encoder_if: request/data side and LED/status side of the pulse encoder
interface pulse_encoder_if #(
    parameter int PACKET_SIZE = 8
);
    logic [PACKET_SIZE-1:0] data_in;
    logic send;
    logic ready;
    logic signal;
    logic done;
    modport master (output data_in, send, input ready, signal, done);
    modport slave (input data_in, send, output ready, signal, done);
endinterface

// File: rtl/pulse_encoder.sv
// pulse_encoder: serialises a word LSB first as single-cycle pulses whose spacing encodes each bit
module pulse_encoder #(
    parameter int PACKET_SIZE = 8,
    parameter int INTERVAL_LOW = 2,
    parameter int INTERVAL_HIGH = 4,
    parameter int GUARD = 4,
    parameter int CNT_W = 4
) (
    input logic clock,
    input logic reset,
    pulse_encoder_if.slave bus
);
    localparam int IDX_W = PACKET_SIZE > 1 ? $clog2(PACKET_SIZE) : 1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_GAP, S_PULSE, S_GUARD} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, gap_last;
    logic [IDX_W-1:0] idx, idx_n;
    logic [PACKET_SIZE-1:0] sr, sr_n;
    logic signal_q, done_q, ready_q;
    if (PACKET_SIZE < 1 || INTERVAL_LOW < 1 || INTERVAL_HIGH <= INTERVAL_LOW || GUARD < 1 ||
        INTERVAL_HIGH >= 2 ** CNT_W || GUARD >= 2 ** CNT_W) begin : g_param_err
        $error("pulse_encoder: invalid parameters or CNT_W too narrow");
    end
    assign gap_last = sr[0] ? CNT_W'(INTERVAL_HIGH - 1) : CNT_W'(INTERVAL_LOW - 1);
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        idx_n = idx;
        sr_n = sr;
        case (state)
            S_IDLE: begin
                if (bus.send) begin
                    state_n = S_START;
                    sr_n = bus.data_in;
                end
            end
            S_START: begin
                state_n = S_GAP;
                idx_n = '0;
                cnt_n = '0;
            end
            S_GAP: begin
                state_n = cnt == gap_last ? S_PULSE : S_GAP;
                cnt_n = cnt == gap_last ? cnt : cnt + 1'b1;
            end
            S_PULSE: begin
                cnt_n = '0;
                if (idx == IDX_W'(PACKET_SIZE - 1)) begin
                    state_n = S_GUARD;
                end else begin
                    state_n = S_GAP;
                    idx_n = idx + 1'b1;
                    sr_n = sr >> 1;
                end
            end
            S_GUARD: begin
                state_n = cnt == CNT_W'(GUARD - 1) ? S_IDLE : S_GUARD;
                cnt_n = cnt == CNT_W'(GUARD - 1) ? cnt : cnt + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end
    // outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt <= '0;
            idx <= '0;
            sr <= '0;
            signal_q <= 1'b0;
            done_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
            sr <= sr_n;
            signal_q <= state_n == S_START || state_n == S_PULSE;
            done_q <= state == S_GUARD && state_n == S_IDLE;
            ready_q <= state_n == S_IDLE;
        end
    end
    assign bus.signal = signal_q;
    assign bus.done = done_q;
    assign bus.ready = ready_q;
endmodule
